// File: rtl/ili9341_pkg.sv
// ili9341_pkg
// Shared definitions for the ILI9341 write-bus decoder:
//   - command opcodes recognised by the decoder
//   - decoder state enumeration
//   - RGB565 field widths (pixel word width derives from them)
package ili9341_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  localparam int RGB_R_W = 5;
  localparam int RGB_G_W = 6;
  localparam int RGB_B_W = 5;
  localparam int PIX_W   = RGB_R_W + RGB_G_W + RGB_B_W;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CA0, ST_CA1, ST_CA2, ST_CA3,
    ST_PA0, ST_PA1, ST_PA2, ST_PA3,
    ST_RAM_HI, ST_RAM_LO,
    ST_SKIP
  } dec_state_e;

endpackage

// File: rtl/ili9341_bus_decoder.sv
// ili9341_bus_decoder
// Panel-side model of the ILI9341 8080 write bus. Bytes are taken on the
// rising edge of write_edge, commands are decoded, the CASET/PASET address
// window is tracked and every two RAMWR data bytes yield one addressed
// RGB565 pixel.
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   nreset          panel hardware reset (active low, synchronous)
//   cmd_data        1 = data byte, 0 = command byte
//   write_edge      write strobe, byte taken on its rising edge
//   dout[7:0]       bus byte
//   cmd_valid       one-cycle pulse per accepted command
//   cmd_code[7:0]   last accepted command
//   pix_valid       one-cycle pulse per completed pixel
//   pix_x/pix_y     pixel column/page, pix_data RGB565 (first byte high)
//   frame_start     one-cycle pulse on RAMWR
//   display_on      level from DISPON, sleep_out level from SLPOUT
module ili9341_bus_decoder
  import ili9341_pkg::*;
#(
  parameter int DEF_EC = 239,
  parameter int DEF_EP = 319
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             nreset,
  input  logic             cmd_data,
  input  logic             write_edge,
  input  logic [7:0]       dout,
  output logic             cmd_valid,
  output logic [7:0]       cmd_code,
  output logic             pix_valid,
  output logic [8:0]       pix_x,
  output logic [8:0]       pix_y,
  output logic [PIX_W-1:0] pix_data,
  output logic             frame_start,
  output logic             display_on,
  output logic             sleep_out
);

  localparam logic [8:0] EC_RST = 9'(DEF_EC);
  localparam logic [8:0] EP_RST = 9'(DEF_EP);

  dec_state_e       state_q, state_d;
  logic             we_prev_q, we_prev_d;
  logic [8:0]       sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
  logic [8:0]       cx_q, cx_d, cy_q, cy_d;
  logic             par_hi_q, par_hi_d;
  logic [7:0]       hi_q, hi_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [7:0]       cmd_code_q, cmd_code_d;
  logic             pix_valid_q, pix_valid_d;
  logic [8:0]       pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [PIX_W-1:0] pix_data_q, pix_data_d;
  logic             frame_start_q, frame_start_d;
  logic             display_on_q, display_on_d;
  logic             sleep_out_q, sleep_out_d;

  logic accept;
  logic clr_panel;

  always_comb begin
    accept    = write_edge && !we_prev_q && nreset;
    // Panel reset and SWRESET share the same window/level clearing.
    clr_panel = !nreset || (accept && !cmd_data && dout == CMD_SWRESET);

    state_d       = state_q;
    we_prev_d     = write_edge;
    sc_d          = sc_q;
    ec_d          = ec_q;
    sp_d          = sp_q;
    ep_d          = ep_q;
    cx_d          = cx_q;
    cy_d          = cy_q;
    par_hi_d      = par_hi_q;
    hi_d          = hi_q;
    cmd_valid_d   = 1'b0;
    cmd_code_d    = cmd_code_q;
    pix_valid_d   = 1'b0;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_data_d    = pix_data_q;
    frame_start_d = 1'b0;
    display_on_d  = display_on_q;
    sleep_out_d   = sleep_out_q;

    if (accept && !cmd_data) begin
      // A command always restarts decoding; a half-received pixel is dropped.
      cmd_valid_d = 1'b1;
      cmd_code_d  = dout;
      case (dout)
        CMD_CASET: state_d = ST_CA0;
        CMD_PASET: state_d = ST_PA0;
        CMD_RAMWR: begin
          state_d       = ST_RAM_HI;
          cx_d          = sc_q;
          cy_d          = sp_q;
          frame_start_d = 1'b1;
        end
        CMD_SWRESET: state_d = ST_IDLE;
        CMD_SLPOUT: begin
          state_d     = ST_IDLE;
          sleep_out_d = 1'b1;
        end
        CMD_DISPON: begin
          state_d      = ST_IDLE;
          display_on_d = 1'b1;
        end
        default: state_d = ST_SKIP;
      endcase
    end else if (accept) begin
      case (state_q)
        ST_CA0: begin par_hi_d = dout[0]; state_d = ST_CA1; end
        ST_CA1: begin sc_d = {par_hi_q, dout}; state_d = ST_CA2; end
        ST_CA2: begin par_hi_d = dout[0]; state_d = ST_CA3; end
        ST_CA3: begin ec_d = {par_hi_q, dout}; state_d = ST_IDLE; end
        ST_PA0: begin par_hi_d = dout[0]; state_d = ST_PA1; end
        ST_PA1: begin sp_d = {par_hi_q, dout}; state_d = ST_PA2; end
        ST_PA2: begin par_hi_d = dout[0]; state_d = ST_PA3; end
        ST_PA3: begin ep_d = {par_hi_q, dout}; state_d = ST_IDLE; end
        ST_RAM_HI: begin hi_d = dout; state_d = ST_RAM_LO; end
        ST_RAM_LO: begin
          pix_valid_d = 1'b1;
          pix_x_d     = cx_q;
          pix_y_d     = cy_q;
          pix_data_d  = {hi_q, dout};
          state_d     = ST_RAM_HI;
          // >= rather than == so an inverted window still wraps.
          if (cx_q >= ec_q) begin
            cx_d = sc_q;
            cy_d = (cy_q >= ep_q) ? sp_q : cy_q + 9'd1;
          end else begin
            cx_d = cx_q + 9'd1;
          end
        end
        default: ;
      endcase
    end

    if (clr_panel) begin
      state_d      = ST_IDLE;
      sc_d         = 9'd0;
      ec_d         = EC_RST;
      sp_d         = 9'd0;
      ep_d         = EP_RST;
      display_on_d = 1'b0;
      sleep_out_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      we_prev_q     <= 1'b0;
      sc_q          <= 9'd0;
      ec_q          <= EC_RST;
      sp_q          <= 9'd0;
      ep_q          <= EP_RST;
      cx_q          <= 9'd0;
      cy_q          <= 9'd0;
      par_hi_q      <= 1'b0;
      hi_q          <= 8'd0;
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= 8'd0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= 9'd0;
      pix_y_q       <= 9'd0;
      pix_data_q    <= '0;
      frame_start_q <= 1'b0;
      display_on_q  <= 1'b0;
      sleep_out_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      we_prev_q     <= we_prev_d;
      sc_q          <= sc_d;
      ec_q          <= ec_d;
      sp_q          <= sp_d;
      ep_q          <= ep_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      par_hi_q      <= par_hi_d;
      hi_q          <= hi_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_code_q    <= cmd_code_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_data_q    <= pix_data_d;
      frame_start_q <= frame_start_d;
      display_on_q  <= display_on_d;
      sleep_out_q   <= sleep_out_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_code    = cmd_code_q;
  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_data    = pix_data_q;
  assign frame_start = frame_start_q;
  assign display_on  = display_on_q;
  assign sleep_out   = sleep_out_q;

endmodule

// File: tb/tb_ili9341_bus_decoder.sv
// Directed testbench for ili9341_bus_decoder.
module tb_ili9341_bus_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        nreset = 1'b1;
  logic        cmd_data = 1'b0;
  logic        write_edge = 1'b0;
  logic [7:0]  dout = 8'd0;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic        pix_valid;
  logic [8:0]  pix_x;
  logic [8:0]  pix_y;
  logic [15:0] pix_data;
  logic        frame_start;
  logic        display_on;
  logic        sleep_out;

  int n_pass = 0;
  int n_total = 0;

  int pix_cnt = 0;
  int cmd_cnt = 0;
  int fs_cnt = 0;
  logic [8:0]  px_log [64];
  logic [8:0]  py_log [64];
  logic [15:0] pd_log [64];

  ili9341_bus_decoder #(.DEF_EC(239), .DEF_EP(319)) dut (
    .clk(clk), .reset(reset), .nreset(nreset), .cmd_data(cmd_data),
    .write_edge(write_edge), .dout(dout), .cmd_valid(cmd_valid),
    .cmd_code(cmd_code), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_y(pix_y), .pix_data(pix_data), .frame_start(frame_start),
    .display_on(display_on), .sleep_out(sleep_out)
  );

  always #5 clk = ~clk;

  // Pulse monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (pix_valid) begin
      if (pix_cnt < 64) begin
        px_log[pix_cnt] = pix_x;
        py_log[pix_cnt] = pix_y;
        pd_log[pix_cnt] = pix_data;
      end
      pix_cnt = pix_cnt + 1;
    end
    if (cmd_valid) cmd_cnt = cmd_cnt + 1;
    if (frame_start) fs_cnt = fs_cnt + 1;
  end

  // One strobe: high for one cycle, low for one cycle (2-cycle spacing).
  task automatic send_byte(input logic cd, input logic [7:0] b);
    @(negedge clk);
    cmd_data = cd;
    dout = b;
    write_edge = 1'b1;
    @(negedge clk);
    write_edge = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({cmd_valid, cmd_code, pix_valid, pix_x, pix_y, pix_data, frame_start,
         display_on, sleep_out} !== '0) begin
      $display("FAIL reset_outputs: got %h/%h/%h/%h/%h/%h/%h/%h/%h, want all 0",
               cmd_valid, cmd_code, pix_valid, pix_x, pix_y, pix_data,
               frame_start, display_on, sleep_out);
    end else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_defaults;
    int fs0, p0;
    fs0 = fs_cnt;
    p0 = pix_cnt;
    send_byte(1'b0, 8'h2C);
    n_total++;
    if (fs_cnt - fs0 !== 1) $display("FAIL defaults_frame_start: got %0d want 1", fs_cnt - fs0);
    else n_pass++;
    send_byte(1'b1, 8'hF8);
    send_byte(1'b1, 8'h00);
    n_total++;
    if (pix_cnt - p0 !== 1) $display("FAIL defaults_pix_count: got %0d want 1", pix_cnt - p0);
    else n_pass++;
    n_total++;
    if ({px_log[p0], py_log[p0], pd_log[p0]} !== {9'd0, 9'd0, 16'hF800})
      $display("FAIL defaults_pixel: got (%0d,%0d) %h want (0,0) f800",
               px_log[p0], py_log[p0], pd_log[p0]);
    else n_pass++;
  endtask

  task automatic test_window_wrap;
    int p0;
    logic [8:0] ex [7];
    logic [8:0] ey [7];
    ex = '{9'd10, 9'd11, 9'd12, 9'd10, 9'd11, 9'd12, 9'd10};
    ey = '{9'd5, 9'd5, 9'd5, 9'd6, 9'd6, 9'd6, 9'd5};
    send_byte(1'b0, 8'h2A);
    send_byte(1'b1, 8'd0); send_byte(1'b1, 8'd10);
    send_byte(1'b1, 8'd0); send_byte(1'b1, 8'd12);
    send_byte(1'b0, 8'h2B);
    send_byte(1'b1, 8'd0); send_byte(1'b1, 8'd5);
    send_byte(1'b1, 8'd0); send_byte(1'b1, 8'd6);
    p0 = pix_cnt;
    send_byte(1'b0, 8'h2C);
    for (int k = 0; k < 7; k++) begin
      send_byte(1'b1, 8'(k));
      send_byte(1'b1, 8'hA0 + 8'(k));
    end
    n_total++;
    if (pix_cnt - p0 !== 7) $display("FAIL window_pix_count: got %0d want 7", pix_cnt - p0);
    else n_pass++;
    for (int k = 0; k < 7; k++) begin
      n_total++;
      if ({px_log[p0+k], py_log[p0+k], pd_log[p0+k]} !==
          {ex[k], ey[k], 8'(k), 8'hA0 + 8'(k)})
        $display("FAIL window_pixel%0d: got (%0d,%0d) %h want (%0d,%0d) %h", k,
                 px_log[p0+k], py_log[p0+k], pd_log[p0+k], ex[k], ey[k],
                 {8'(k), 8'hA0 + 8'(k)});
      else n_pass++;
    end
  endtask

  task automatic test_abort;
    int p0;
    p0 = pix_cnt;
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'hAB);
    send_byte(1'b0, 8'h29);
    n_total++;
    if (pix_cnt !== p0) $display("FAIL abort_no_pixel: got %0d pixels want 0", pix_cnt - p0);
    else n_pass++;
    n_total++;
    if ({display_on, cmd_code} !== {1'b1, 8'h29})
      $display("FAIL abort_levels: got on=%b code=%h want on=1 code=29", display_on, cmd_code);
    else n_pass++;
    // The dropped 0xAB byte must not leak into the next pixel.
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h12);
    send_byte(1'b1, 8'h34);
    n_total++;
    if ({px_log[p0], py_log[p0], pd_log[p0]} !== {9'd10, 9'd5, 16'h1234})
      $display("FAIL abort_next_pixel: got (%0d,%0d) %h want (10,5) 1234",
               px_log[p0], py_log[p0], pd_log[p0]);
    else n_pass++;
  endtask

  task automatic test_unknown_cmd;
    int c0, p0, f0;
    c0 = cmd_cnt; p0 = pix_cnt; f0 = fs_cnt;
    send_byte(1'b0, 8'h36);
    send_byte(1'b1, 8'h48);
    n_total++;
    if ({cmd_cnt - c0, pix_cnt - p0, fs_cnt - f0} !== {32'd1, 32'd0, 32'd0})
      $display("FAIL unknown_pulses: got cmd=%0d pix=%0d fs=%0d want 1/0/0",
               cmd_cnt - c0, pix_cnt - p0, fs_cnt - f0);
    else n_pass++;
    n_total++;
    if ({cmd_code, display_on, sleep_out} !== {8'h36, 1'b1, 1'b0})
      $display("FAIL unknown_state: got code=%h on=%b sleep=%b want 36/1/0",
               cmd_code, display_on, sleep_out);
    else n_pass++;
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h56);
    send_byte(1'b1, 8'h78);
    n_total++;
    if ({px_log[p0], py_log[p0], pd_log[p0]} !== {9'd10, 9'd5, 16'h5678})
      $display("FAIL unknown_then_ramwr: got (%0d,%0d) %h want (10,5) 5678",
               px_log[p0], py_log[p0], pd_log[p0]);
    else n_pass++;
  endtask

  task automatic test_sleep_swreset;
    int p0;
    send_byte(1'b0, 8'h11);
    n_total++;
    if (sleep_out !== 1'b1) $display("FAIL slpout_level: got %b want 1", sleep_out);
    else n_pass++;
    send_byte(1'b0, 8'h01);
    n_total++;
    if ({display_on, sleep_out} !== 2'b00)
      $display("FAIL swreset_levels: got on=%b sleep=%b want 0/0", display_on, sleep_out);
    else n_pass++;
    p0 = pix_cnt;
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h9A);
    send_byte(1'b1, 8'hBC);
    n_total++;
    if ({px_log[p0], py_log[p0], pd_log[p0]} !== {9'd0, 9'd0, 16'h9ABC})
      $display("FAIL swreset_window: got (%0d,%0d) %h want (0,0) 9abc",
               px_log[p0], py_log[p0], pd_log[p0]);
    else n_pass++;
  endtask

  task automatic test_panel_reset;
    int c0, p0;
    send_byte(1'b0, 8'h29);
    send_byte(1'b0, 8'h2A);
    send_byte(1'b1, 8'd0); send_byte(1'b1, 8'd50);
    send_byte(1'b1, 8'd0); send_byte(1'b1, 8'd60);
    @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    n_total++;
    if (display_on !== 1'b0) $display("FAIL nreset_display: got %b want 0", display_on);
    else n_pass++;
    c0 = cmd_cnt;
    send_byte(1'b0, 8'h29);
    send_byte(1'b1, 8'h11);
    n_total++;
    if ({cmd_cnt - c0, 31'd0, display_on} !== {32'd0, 32'd0})
      $display("FAIL nreset_ignored: got cmds=%0d on=%b want 0/0", cmd_cnt - c0, display_on);
    else n_pass++;
    @(negedge clk);
    nreset = 1'b1;
    p0 = pix_cnt;
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h11);
    send_byte(1'b1, 8'h22);
    n_total++;
    if ({px_log[p0], py_log[p0], pd_log[p0], display_on} !== {9'd0, 9'd0, 16'h1122, 1'b0})
      $display("FAIL nreset_ramwr: got (%0d,%0d) %h on=%b want (0,0) 1122 on=0",
               px_log[p0], py_log[p0], pd_log[p0], display_on);
    else n_pass++;
  endtask

  task automatic test_strobe_edges;
    int c0;
    c0 = cmd_cnt;
    @(negedge clk);
    cmd_data = 1'b0;
    dout = 8'h00;
    write_edge = 1'b1;
    repeat (5) @(negedge clk);
    write_edge = 1'b0;
    #1;
    n_total++;
    if (cmd_cnt - c0 !== 1) $display("FAIL strobe_held: got %0d accepts want 1", cmd_cnt - c0);
    else n_pass++;
    c0 = cmd_cnt;
    send_byte(1'b0, 8'h00);
    send_byte(1'b0, 8'h11);
    n_total++;
    if ({cmd_cnt - c0, 24'd0, cmd_code} !== {32'd2, 32'h11})
      $display("FAIL strobe_back_to_back: got %0d accepts code=%h want 2 code=11",
               cmd_cnt - c0, cmd_code);
    else n_pass++;
  endtask

  task automatic test_mid_reset;
    int p0;
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h55);
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if ({cmd_code, pix_data, sleep_out} !== {8'h00, 16'h0000, 1'b0})
      $display("FAIL mid_reset_clear: got code=%h data=%h sleep=%b want 00/0000/0",
               cmd_code, pix_data, sleep_out);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    p0 = pix_cnt;
    send_byte(1'b1, 8'h66);
    send_byte(1'b1, 8'h77);
    n_total++;
    if (pix_cnt !== p0) $display("FAIL mid_reset_idle: got %0d pixels want 0", pix_cnt - p0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_reset_defaults();
    test_window_wrap();
    test_abort();
    test_unknown_cmd();
    test_sleep_swreset();
    test_panel_reset();
    test_strobe_edges();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
